// File: rtl/pipelined_carry_select_adder_pkg.sv
// pipelined_carry_select_adder_pkg: default geometry shared by the adder and its ripple blocks
package pipelined_carry_select_adder_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLOCK = 8;
endpackage

// File: rtl/pipelined_carry_select_adder_rca_block.sv
// rca_block: W-bit ripple adder; s/co = a+b+ci, cm = carry into the MSB (for overflow)
module rca_block #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         cm
);
   always_comb begin
      {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      cm = s[W-1] ^ a[W-1] ^ b[W-1];
   end
endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: 2-stage carry-select add/sub with valid/ready on both sides
//   in:  clk, rst_n (async, active-low), in_valid, a, b, cin, sub, out_ready
//   out: in_ready, out_valid, sum, cout (1 = no borrow on sub), ovf (signed overflow)
module pipelined_carry_select_adder
   import pipelined_carry_select_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NBLK = WIDTH / BLOCK;
   if (WIDTH % BLOCK != 0 || BLOCK > WIDTH) begin : g_bad_cfg
      $error("WIDTH must be a positive multiple of BLOCK");
   end
   logic [WIDTH-1:0] b_eff, s_lo_w, s_hi_w;
   logic             ci_eff;
   logic [NBLK-1:0]  co_lo_w, co_hi_w, cm_lo_w, cm_hi_w;
   logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
   logic [WIDTH-1:0] s_lo_q, s_lo_d, s_hi_q, s_hi_d, sum_q, sum_d, res;
   logic [NBLK-1:0]  co_lo_q, co_lo_d, co_hi_q, co_hi_d, cm_lo_q, cm_lo_d, cm_hi_q, cm_hi_d;
   logic             cout_q, cout_d, ovf_q, ovf_d;
   logic             s1_load, s2_load, take, sel_c, msb_c;
   assign b_eff  = sub ? ~b : b;
   assign ci_eff = sub | cin;
   rca_block #(.W(BLOCK)) u_blk0 (
      .a(a[BLOCK-1:0]), .b(b_eff[BLOCK-1:0]), .ci(ci_eff),
      .s(s_lo_w[BLOCK-1:0]), .co(co_lo_w[0]), .cm(cm_lo_w[0])
   );
   // Block 0 already has its real carry-in, so both candidate slots carry the same result.
   assign s_hi_w[BLOCK-1:0] = s_lo_w[BLOCK-1:0];
   assign co_hi_w[0] = co_lo_w[0];
   assign cm_hi_w[0] = cm_lo_w[0];
   for (genvar k = 1; k < NBLK; k++) begin : g_blk
      rca_block #(.W(BLOCK)) u_lo (
         .a(a[k*BLOCK +: BLOCK]), .b(b_eff[k*BLOCK +: BLOCK]), .ci(1'b0),
         .s(s_lo_w[k*BLOCK +: BLOCK]), .co(co_lo_w[k]), .cm(cm_lo_w[k])
      );
      rca_block #(.W(BLOCK)) u_hi (
         .a(a[k*BLOCK +: BLOCK]), .b(b_eff[k*BLOCK +: BLOCK]), .ci(1'b1),
         .s(s_hi_w[k*BLOCK +: BLOCK]), .co(co_hi_w[k]), .cm(cm_hi_w[k])
      );
   end
   always_comb begin
      s2_load     = !out_valid_q || out_ready;
      s1_load     = !s1_valid_q || s2_load;
      take        = s1_load && in_valid;
      s1_valid_d  = s1_load ? in_valid : s1_valid_q;
      s_lo_d      = take ? s_lo_w  : s_lo_q;
      s_hi_d      = take ? s_hi_w  : s_hi_q;
      co_lo_d     = take ? co_lo_w : co_lo_q;
      co_hi_d     = take ? co_hi_w : co_hi_q;
      cm_lo_d     = take ? cm_lo_w : cm_lo_q;
      cm_hi_d     = take ? cm_hi_w : cm_hi_q;
      // Select chain starts at 0 so block 0 falls out of the same loop as the upper blocks.
      sel_c       = 1'b0;
      msb_c       = 1'b0;
      res         = '0;
      for (int k = 0; k < NBLK; k++) begin
         res[k*BLOCK +: BLOCK] = sel_c ? s_hi_q[k*BLOCK +: BLOCK] : s_lo_q[k*BLOCK +: BLOCK];
         msb_c = sel_c ? cm_hi_q[k] : cm_lo_q[k];
         sel_c = sel_c ? co_hi_q[k] : co_lo_q[k];
      end
      out_valid_d = s2_load ? s1_valid_q : out_valid_q;
      sum_d       = (s2_load && s1_valid_q) ? res           : sum_q;
      cout_d      = (s2_load && s1_valid_q) ? sel_c         : cout_q;
      ovf_d       = (s2_load && s1_valid_q) ? msb_c ^ sel_c : ovf_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s_lo_q      <= '0;
         s_hi_q      <= '0;
         co_lo_q     <= '0;
         co_hi_q     <= '0;
         cm_lo_q     <= '0;
         cm_hi_q     <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s_lo_q      <= s_lo_d;
         s_hi_q      <= s_hi_d;
         co_lo_q     <= co_lo_d;
         co_hi_q     <= co_hi_d;
         cm_lo_q     <= cm_lo_d;
         cm_hi_q     <= cm_hi_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end
   assign in_ready  = s1_load;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule
